// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser
//   Drains bytes from the host-link receive FIFO and assembles framed control
//   commands of the form: SYNC, opcode, length N, N payload bytes, checksum.
//   A validated frame is presented downstream as one command word on a
//   valid/ready handshake.
//   The checksum is the two's complement of the 8-bit sum of opcode, length
//   and payload. Malformed or stalled frames are dropped, and each one is
//   reported on err/err_code.
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset
//   fifo_data      FIFO head byte, valid while fifo_nonempty
//   fifo_nonempty  FIFO holds at least one byte
//   fifo_next      pop strobe; head byte is consumed at the rising edge
//   cmd_valid      command available (held until cmd_ready)
//   cmd_ready      downstream accepts the command
//   cmd_opcode     command opcode
//   cmd_len        payload byte count
//   cmd_payload    byte i at [8i+7:8i]; bytes at or above cmd_len are zero
//   err            one-cycle error pulse
//   err_code       1 = length, 2 = checksum, 3 = timeout (holds last value)
//   err_count      saturating error count
module cmd_frame_parser #(
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               fifo_data,
  input  logic                     fifo_nonempty,
  output logic                     fifo_next,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_opcode,
  output logic [7:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [7:0]               err_count
);

  localparam int            TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The error fires on the idle edge that would take the counter to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);
  localparam int            PW      = 8 * MAX_PAYLOAD;

  typedef enum logic [2:0] {
    S_HUNT, S_OPCODE, S_LENGTH, S_PAYLOAD, S_CHECK, S_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      sum_reg, sum_next;
  logic [7:0]      idx_reg, idx_next;
  logic [7:0]      len_reg, len_next;
  logic [7:0]      op_reg, op_next;
  logic [PW-1:0]   pay_reg, pay_next;
  logic [TW-1:0]   to_reg, to_next;
  logic            cmd_valid_reg, cmd_valid_next;
  logic [7:0]      cmd_opcode_reg, cmd_opcode_next;
  logic [7:0]      cmd_len_reg, cmd_len_next;
  logic [PW-1:0]   cmd_payload_reg, cmd_payload_next;
  logic            err_reg, err_next;
  logic [1:0]      err_code_reg, err_code_next;
  logic [7:0]      err_count_reg, err_count_next;

  logic            pop;
  logic            err_hit;
  logic [7:0]      sum_add;
  logic [7:0]      idx_inc;
  logic [MAX_PAYLOAD-1:0] byte_sel;

  // Popping is gated by reset so nothing is consumed while the block is held.
  assign pop       = fifo_nonempty && reset_n && (state_reg != S_HOLD);
  assign fifo_next = pop;
  assign sum_add   = sum_reg + fifo_data;
  assign idx_inc   = idx_reg + 8'd1;

  for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_sel
    assign byte_sel[gi] = (idx_reg == 8'(gi));
  end

  always_comb begin
    state_next       = state_reg;
    sum_next         = sum_reg;
    idx_next         = idx_reg;
    len_next         = len_reg;
    op_next          = op_reg;
    pay_next         = pay_reg;
    to_next          = to_reg;
    cmd_valid_next   = cmd_valid_reg;
    cmd_opcode_next  = cmd_opcode_reg;
    cmd_len_next     = cmd_len_reg;
    cmd_payload_next = cmd_payload_reg;
    err_hit          = 1'b0;
    err_code_next    = err_code_reg;

    case (state_reg)
      S_HUNT: begin
        if (pop && fifo_data == SYNC_BYTE) begin
          state_next = S_OPCODE;
          sum_next   = '0;
          idx_next   = '0;
          pay_next   = '0;
        end
      end
      S_OPCODE: begin
        if (pop) begin
          op_next    = fifo_data;
          sum_next   = sum_add;
          state_next = S_LENGTH;
        end
      end
      S_LENGTH: begin
        if (pop) begin
          len_next = fifo_data;
          sum_next = sum_add;
          if (fifo_data > MAX_LEN) begin
            err_hit       = 1'b1;
            err_code_next = 2'd1;
            state_next    = S_HUNT;
          end else if (fifo_data == 8'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          // len_reg never exceeds MAX_PAYLOAD here, so idx_reg stays in range.
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (byte_sel[i]) pay_next[8*i +: 8] = fifo_data;
          end
          sum_next = sum_add;
          idx_next = idx_inc;
          if (idx_inc == len_reg) state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pop) begin
          if (sum_add == 8'h00) begin
            state_next       = S_HOLD;
            cmd_valid_next   = 1'b1;
            cmd_opcode_next  = op_reg;
            cmd_len_next     = len_reg;
            cmd_payload_next = pay_reg;
          end else begin
            err_hit       = 1'b1;
            err_code_next = 2'd2;
            state_next    = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = S_HUNT;
        end
      end
      default: state_next = S_HUNT;
    endcase

    // Inter-byte timeout: only counts while a frame is open and the FIFO
    // gives us nothing; any consumed byte restarts it.
    if (state_reg inside {S_OPCODE, S_LENGTH, S_PAYLOAD, S_CHECK}) begin
      if (pop) begin
        to_next = '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        if (to_reg == TO_LAST) begin
          to_next       = '0;
          err_hit       = 1'b1;
          err_code_next = 2'd3;
          state_next    = S_HUNT;
        end else begin
          to_next = to_reg + 1'b1;
        end
      end
    end else begin
      to_next = '0;
    end

    err_next       = err_hit;
    err_count_next = (err_hit && err_count_reg != 8'hFF) ? err_count_reg + 8'd1 : err_count_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_HUNT;
      sum_reg         <= '0;
      idx_reg         <= '0;
      len_reg         <= '0;
      op_reg          <= '0;
      pay_reg         <= '0;
      to_reg          <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_opcode_reg  <= '0;
      cmd_len_reg     <= '0;
      cmd_payload_reg <= '0;
      err_reg         <= 1'b0;
      err_code_reg    <= '0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      sum_reg         <= sum_next;
      idx_reg         <= idx_next;
      len_reg         <= len_next;
      op_reg          <= op_next;
      pay_reg         <= pay_next;
      to_reg          <= to_next;
      cmd_valid_reg   <= cmd_valid_next;
      cmd_opcode_reg  <= cmd_opcode_next;
      cmd_len_reg     <= cmd_len_next;
      cmd_payload_reg <= cmd_payload_next;
      err_reg         <= err_next;
      err_code_reg    <= err_code_next;
      err_count_reg   <= err_count_next;
    end
  end

  assign cmd_valid   = cmd_valid_reg;
  assign cmd_opcode  = cmd_opcode_reg;
  assign cmd_len     = cmd_len_reg;
  assign cmd_payload = cmd_payload_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser
//   Directed bench for cmd_frame_parser (MAX_PAYLOAD = 8, TIMEOUT_CYCLES = 16).
//   A queue models the upstream FIFO; its head is presented on the falling
//   edge and popped on the rising edge where fifo_next is high.
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  fifo_data;
  logic        fifo_nonempty;
  logic        fifo_next;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  cmd_frame_parser #(
    .MAX_PAYLOAD   (8),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_data    (fifo_data),
    .fifo_nonempty(fifo_nonempty),
    .fifo_next    (fifo_next),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_len      (cmd_len),
    .cmd_payload  (cmd_payload),
    .err          (err),
    .err_code     (err_code),
    .err_count    (err_count)
  );

  logic [7:0] fifo_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  int idle_cnt = 0;
  int cyc_cnt = 0;
  int err_pulses = 0;

  // FIFO model: pop at the rising edge, present the new head at the falling edge.
  always @(posedge clk) begin
    cyc_cnt++;
    if (fifo_next) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
  end

  always @(negedge clk) begin
    fifo_nonempty = (fifo_q.size() != 0);
    fifo_data     = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    if (err) begin
      err_pulses++;
      $display("[%0t] err code=%0d count=%0d", $time, err_code, err_count);
    end
    if (cmd_valid && cmd_ready)
      $display("[%0t] cmd op=%h len=%0d payload=%h", $time, cmd_opcode, cmd_len, cmd_payload);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next cmd_valid or err, sampled on falling edges.
  task automatic wait_event(input string tag, output bit saw_cmd, output bit saw_err);
    saw_cmd = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_valid || err) begin
        saw_cmd = cmd_valid;
        saw_err = err;
        return;
      end
    end
    chk({tag, "_no_event"}, 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_drained"}, 64'(fifo_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit c, e;
    int t0, e0;

    reset_n       = 1'b0;
    cmd_ready     = 1'b0;
    fifo_nonempty = 1'b0;
    fifo_data     = 8'h00;

    // Reset state, with a frame already waiting in the FIFO.
    fifo_q = {8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    repeat (3) @(negedge clk);
    chk("rst_nonempty", fifo_nonempty, 1'b1);
    chk("rst_fifo_next", fifo_next, 1'b0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_opcode", cmd_opcode, 8'h00);
    chk("rst_len", cmd_len, 8'h00);
    chk("rst_payload", cmd_payload, 64'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_err_count", err_count, 8'd0);

    // 1: preloaded frame, ready high.
    cmd_ready = 1'b1;
    pops      = 0;
    t0        = cyc_cnt;
    reset_n   = 1'b1;
    wait_event("t1", c, e);
    chk("t1_valid", c, 1'b1);
    chk("t1_latency", 64'(cyc_cnt - t0), 64'd6);
    chk("t1_pops", 64'(pops), 64'd6);
    chk("t1_opcode", cmd_opcode, 8'h10);
    chk("t1_len", cmd_len, 8'd2);
    chk("t1_payload", cmd_payload, 64'h0000_0000_0000_0201);
    chk("t1_err_pulses", 64'(err_pulses), 64'd0);
    @(negedge clk);
    chk("t1_valid_drop", cmd_valid, 1'b0);

    // 2: backpressure for 20 cycles with a second frame queued behind.
    cmd_ready = 1'b0;
    fifo_q = {fifo_q, 8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB, 8'hA5, 8'h20, 8'h00, 8'hE0};
    wait_event("t2a", c, e);
    chk("t2_valid", c, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", cmd_valid, 1'b1);
      chk("t2_hold_nonempty", fifo_nonempty, 1'b1);
      chk("t2_hold_fifo_next", fifo_next, 1'b0);
      chk("t2_hold_opcode", cmd_opcode, 8'h10);
      chk("t2_hold_payload", cmd_payload, 64'h0201);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept_drop", cmd_valid, 1'b0);
    chk("t2_resume_pop", fifo_next, 1'b1);
    wait_event("t2b", c, e);
    chk("t2b_valid", c, 1'b1);
    chk("t2b_opcode", cmd_opcode, 8'h20);
    chk("t2b_len", cmd_len, 8'd0);
    chk("t2b_payload", cmd_payload, 64'h0);

    // 3: leading garbage, then a zero-length frame; then a bad checksum.
    fifo_q = {fifo_q, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h00, 8'hE0};
    wait_event("t3a", c, e);
    chk("t3_valid", c, 1'b1);
    chk("t3_opcode", cmd_opcode, 8'h20);
    chk("t3_len", cmd_len, 8'd0);
    fifo_q = {fifo_q, 8'hA5, 8'h20, 8'h00, 8'hE1};
    wait_event("t3b", c, e);
    chk("t3_err", e, 1'b1);
    chk("t3_no_valid", cmd_valid, 1'b0);
    chk("t3_err_code", err_code, 2'd2);
    chk("t3_err_count", err_count, 8'd1);

    // 4: length 9 exceeds MAX_PAYLOAD, followed by a good frame.
    fifo_q = {fifo_q, 8'hA5, 8'h01, 8'h09, 8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    wait_event("t4a", c, e);
    chk("t4_err", e, 1'b1);
    chk("t4_err_code", err_code, 2'd1);
    chk("t4_err_count", err_count, 8'd2);
    wait_event("t4b", c, e);
    chk("t4_valid", c, 1'b1);
    chk("t4_opcode", cmd_opcode, 8'h10);
    chk("t4_payload", cmd_payload, 64'h0201);
    chk("t4_code_held", err_code, 2'd1);

    // 5: stall after the opcode; timeout after exactly 16 idle edges.
    fifo_q = {fifo_q, 8'hA5, 8'h01};
    wait_event("t5a", c, e);
    chk("t5_err", e, 1'b1);
    chk("t5_err_code", err_code, 2'd3);
    chk("t5_idle_edges", 64'(idle_cnt), 64'd16);
    chk("t5_err_count", err_count, 8'd3);
    fifo_q = {fifo_q, 8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    wait_event("t5b", c, e);
    chk("t5_hunt_valid", c, 1'b1);
    chk("t5_hunt_opcode", cmd_opcode, 8'h10);
    // Reset in the middle of a frame.
    fifo_q = {fifo_q, 8'hA5, 8'h30};
    repeat (5) @(negedge clk);
    e0 = err_pulses;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_valid", cmd_valid, 1'b0);
    chk("t5_rst_opcode", cmd_opcode, 8'h00);
    chk("t5_rst_len", cmd_len, 8'h00);
    chk("t5_rst_payload", cmd_payload, 64'h0);
    chk("t5_rst_err", err, 1'b0);
    chk("t5_rst_err_code", err_code, 2'd0);
    chk("t5_rst_err_count", err_count, 8'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_rst_no_err", 64'(err_pulses - e0), 64'd0);

    // 6: SYNC value inside the payload is data; then error count saturation.
    fifo_q = {fifo_q, 8'hA5, 8'h30, 8'h01, 8'hA5, 8'h2A};
    wait_event("t6a", c, e);
    chk("t6_valid", c, 1'b1);
    chk("t6_opcode", cmd_opcode, 8'h30);
    chk("t6_len", cmd_len, 8'd1);
    chk("t6_payload", cmd_payload, 64'h0000_0000_0000_00A5);
    e0 = err_pulses;
    for (int i = 0; i < 254; i++) fifo_q = {fifo_q, 8'hA5, 8'h01, 8'h09};
    drain("t6a");
    chk("t6_count_254", err_count, 8'd254);
    for (int i = 0; i < 46; i++) fifo_q = {fifo_q, 8'hA5, 8'h01, 8'h09};
    drain("t6b");
    chk("t6_count_sat", err_count, 8'd255);
    chk("t6_pulses", 64'(err_pulses - e0), 64'd300);
    chk("t6_code", err_code, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

- Drains bytes from an upstream `fifo_buffer` (8-bit) and assembles framed control commands.
- Frame format: sync byte, opcode, length N, N payload bytes, checksum.
- Validates each frame and presents it downstream as a single command word on a valid/ready handshake.
- Sits between the host-link receive FIFO and the parameter/register update logic.

## Interface
Parameters:
- `MAX_PAYLOAD`, 8 — maximum payload bytes per frame, 1..255.
- `SYNC_BYTE`, 8'hA5 — frame start marker.
- `TIMEOUT_CYCLES`, 1024 — inter-byte timeout in clocks inside a frame; 0 disables.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — clock.
- `reset_n` in 1 — async active-low reset.
- `fifo_data` in 8 — FIFO head byte, combinationally valid while `fifo_nonempty`.
- `fifo_nonempty` in 1 — FIFO has at least one byte.
- `fifo_next` out 1 — pop; the byte on `fifo_data` is consumed at the rising edge where this is high.
- `cmd_valid` out 1 — command available.
- `cmd_ready` in 1 — downstream accepts the command.
- `cmd_opcode` out 8 — opcode.
- `cmd_len` out 8 — payload byte count.
- `cmd_payload` out 8*MAX_PAYLOAD — byte i at [8i+7:8i]; bytes ≥ `cmd_len` are zero.
- `err` out 1 — one-cycle error pulse.
- `err_code` out 2 — 1 = length, 2 = checksum, 3 = timeout; holds its last value.
- `err_count` out 8 — saturating count of errors.

## Operation
- States and transitions:
  - HUNT: non-sync bytes are discarded; a byte equal to `SYNC_BYTE` → OPCODE.
  - OPCODE → LENGTH.
  - LENGTH: N > MAX_PAYLOAD → length error, HUNT. N = 0 → CHECK. Otherwise → PAYLOAD.
  - PAYLOAD: after N bytes → CHECK.
  - CHECK: checksum byte consumed → HOLD, or checksum error → HUNT.
  - HOLD: on `cmd_valid && cmd_ready` → HUNT.
- Pop rule: `fifo_next = fifo_nonempty && state != HOLD`, combinational.
  - Throughput is one byte per clock.
  - No bytes are popped in HOLD, so backpressure fills the FIFO.
- Checksum:
  - 8-bit running sum, modulo 256, of opcode, length and payload bytes.
  - The frame is valid iff sum + checksum byte == 8'h00 (mod 256).
- On entering OPCODE, clear the payload register, sum and byte index.
- A byte equal to `SYNC_BYTE` seen inside a frame is data. No mid-frame resync.
- Timeout:
  - In OPCODE, LENGTH, PAYLOAD and CHECK, the counter increments on each cycle with no byte consumed.
  - It clears on every consumed byte and on entering HUNT.
  - When it reaches TIMEOUT_CYCLES: timeout error, → HUNT.
- Error handling:
  - Any error pulses `err` for one cycle and loads `err_code`.
  - `err_count` increments and saturates at 255.
  - The partial frame is dropped; `cmd_valid` is never asserted for it.
- `cmd_*` fields are registered and stable for the whole time `cmd_valid` is high.
- Reset mid-frame discards the frame. `err` is not pulsed and `err_count` is unchanged by the discard.

## Timing
- Reset values: state HUNT; `cmd_valid` 0; `cmd_opcode`, `cmd_len`, `cmd_payload` 0; `err` 0; `err_code` 0; `err_count` 0; timeout counter 0.
- `fifo_next` is 0 during reset and whenever `fifo_nonempty` = 0.
- Latency: `cmd_valid` rises in the cycle after the edge that consumes the checksum byte.
  - A back-to-back frame with a payload of N bytes takes N+4 pop cycles, plus 1 cycle to valid.
- Handshake:
  - `cmd_valid` stays high until a cycle with `cmd_ready` = 1.
  - It drops the next cycle, and popping resumes that same cycle (HUNT).
  - `cmd_ready` high before valid has no effect.
- `err` goes high in the cycle after the offending byte or timeout edge.
- Timeout fires exactly TIMEOUT_CYCLES idle cycles after the last consumed in-frame byte.

## Test plan
1. Frame A5 10 02 01 02 EB, FIFO preloaded, `cmd_ready` = 1 → pops on 6 consecutive cycles; `cmd_valid` for 1 cycle with opcode 10, len 2, payload[15:0] = 0201, upper bytes 0; no err.
2. Same frame with `cmd_ready` held 0 for 20 cycles, plus a second frame queued → `cmd_valid` and fields stable; `fifo_next` = 0 throughout; second frame delivered after acceptance.
3. Garbage 00 FF 5A, then A5 20 00 E0 → garbage discarded; command opcode 20, len 0; a checksum byte of E1 instead → `err_code` = 2, `err_count` = 1, no `cmd_valid`.
4. A5 01 09 with MAX_PAYLOAD = 8 → err, `err_code` = 1; following valid frame parsed normally.
5. A5 01, then FIFO empty, TIMEOUT_CYCLES = 16 → err with `err_code` = 3 exactly 16 idle cycles later; state HUNT; `reset_n` pulsed mid-frame → all outputs 0, no err.
6. Payload containing A5, e.g. A5 30 01 A5 2A → accepted, payload byte 0 = A5; 300 bad frames → `err_count` saturates at 255.
